lockstep_cmp: RTL and testbench
===============================

// Module: lockstep_cmp
// PURPOSE
//  Lockstep checker on the bus side of the dual-core lockstep delay stage. The leading core's
//  OBI requests are stored in an NCYCLES-deep delay line and compared, cycle by cycle, with the
//  trailing core's requests. The trailing core runs NCYCLES behind because its responses are delayed.
//  Any divergence is reported to the safety controller as a pulse, a sticky error flag and a saturating count.
// PARAMETERS
//  NCYCLES    2  lead/trail skew in cycles (>=1); depth of the delay line
//  ERR_CNT_W  8  width of the mismatch counter
// PORTS
//  clk_i              in   1          clock
//  rst_i              in   1          asynchronous, active-high reset
//  enable_i           in   1          lockstep checking enabled
//  clear_i            in   1          clear error status (error_o, err_cnt_o, err_src_o)
//  lead_instr_req_i   in   obi_req_t  leading-core instruction request
//  trail_instr_req_i  in   obi_req_t  trailing-core instruction request
//  lead_data_req_i    in   obi_req_t  leading-core data request
//  trail_data_req_i   in   obi_req_t  trailing-core data request
//  mismatch_o         out  1          one-cycle pulse per mismatching compare cycle
//  error_o            out  1          sticky fault flag
//  err_cnt_o          out  ERR_CNT_W  saturating count of mismatching cycles
//  err_src_o          out  2          sticky source: [0] instruction channel, [1] data channel
//  state_o            out  2          FSM state: IDLE=0, FILL=1, CHECK=2, FAULT=3
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, delay line and fill count 0. Reset is asynchronous and may occur mid-operation.
//  Delay line
//  - Two NCYCLES-deep shift registers, one per channel. They shift only in cycles where enable_i=1.
//  - In any cycle with enable_i=0 both shift registers are cleared to 0.
//  - fill_cnt counts shifts since enable_i last rose and saturates at NCYCLES.
//  Compare window
//  - Let t be the first cycle with enable_i=1. Comparing starts at cycle t+NCYCLES: the delayed lead
//    request for cycle t is compared with the trail request of cycle t+NCYCLES.
//  - Comparing is active when enable_i=1 and fill_cnt==NCYCLES. Matching is purely positional; there is no handshake.
//  Mismatch rule (d = delayed lead request, r = trail request)
//  - instr: d.req!=r.req | (d.req & r.req & d.addr!=r.addr). The we, be and wdata fields are ignored.
//  - data:  d.req!=r.req | (d.req & r.req & (d.addr!=r.addr | d.we!=r.we | d.be!=r.be |
//           (d.we & d.wdata!=r.wdata))).
//  Latency: the mismatch is evaluated combinationally in cycle c; all outputs are registered and update in cycle c+1.
//  Status update on a mismatch cycle
//  - mismatch_o pulses 1 and error_o is set.
//  - err_src_o ORs in the failing channel bits.
//  - err_cnt_o increments by 1, saturating at all-ones. A simultaneous instr+data mismatch counts as one increment.
//  clear_i
//  - Zeroes error_o, err_cnt_o and err_src_o. The delay line is untouched.
//  - A same-cycle mismatch wins: status reloads as after a single fresh mismatch (count=1).
//  FSM (registered)
//  - Any state with enable_i=0 -> IDLE. Error status is held in IDLE; only clear_i or reset clears it.
//  - IDLE, enable_i=1 -> FILL.
//  - FILL, on the cycle fill_cnt reaches NCYCLES -> CHECK if error_o=0, otherwise FAULT.
//  - CHECK, on a mismatch -> FAULT.
//  - FAULT, clear_i=1 with no same-cycle mismatch -> CHECK. FAULT keeps comparing and counting.
//  - Dropping enable_i mid-FILL restarts the fill when enable_i is raised again.
// TESTING
//  1 Reset: rst_i=1 for 3 cycles with random inputs -> all outputs 0, state_o=0. Deassert; state stays 0 while enable_i=0.
//  2 Clean run, NCYCLES=2: enable at t; lead instr addr 0x100 at t, trail 0x100 at t+2, identical streams for 50 cycles
//    -> state_o=1 at t+1, 2 from t+2, mismatch_o never 1.
//  3 Data write diverges: lead we=1 wdata 0xDEADBEEF, trail we=1 wdata 0xDEADBEEE, aligned
//    -> next cycle mismatch_o=1 (one cycle), error_o=1, err_cnt_o=1, err_src_o=2'b10, state_o=3.
//  4 Ignored fields: data we=0 with differing wdata, then instr with differing we/be only -> no mismatch.
//  5 Saturation, ERR_CNT_W=2: 5 mismatching cycles, instr and data in the same cycle
//    -> err_cnt_o=3, err_src_o=2'b11, error_o=1.
//  6 clear_i together with a mismatch -> error_o=1, err_cnt_o=1. clear_i alone -> all 0, state_o=2.
//    Drop enable_i in FILL, re-raise -> FILL restarts, and the first compare is 2 cycles after the re-raise.

Source files
------------

// File: rtl/lockstep_cmp.sv
// lockstep_cmp: bus-side comparator for a dual-core lockstep pair.
// The leading core's instruction and data requests are held in an NCYCLES-deep
// delay line and compared position-by-position with the trailing core's
// requests. Divergence raises a pulse, a sticky flag, a sticky source mask and
// a saturating count.
//
// Request vector layout (70 bits, both channels):
//   [69] req  [68:37] addr  [36] we  [35:32] be  [31:0] wdata
module lockstep_cmp #(
  parameter int NCYCLES   = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [69:0]          lead_instr_req_i,
  input  logic [69:0]          trail_instr_req_i,
  input  logic [69:0]          lead_data_req_i,
  input  logic [69:0]          trail_data_req_i,
  output logic                 mismatch_o,
  output logic                 error_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [1:0]           err_src_o,
  output logic [1:0]           state_o
);

  localparam int REQ_B   = 69;
  localparam int ADDR_HI = 68;
  localparam int ADDR_LO = 37;
  localparam int WE_B    = 36;
  localparam int BE_HI   = 35;
  localparam int BE_LO   = 32;
  localparam int WD_HI   = 31;

  localparam int                    FILL_W    = $clog2(NCYCLES + 1);
  localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(NCYCLES);
  localparam logic [ERR_CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [ERR_CNT_W-1:0]  CNT_ONE   = ERR_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Instruction compare only looks at {req, addr}: bit 32 is req, [31:0] is addr.
  function automatic logic instr_mismatch(input logic [32:0] d, input logic [32:0] r);
    logic both;
    both = d[32] & r[32];
    return (d[32] != r[32]) | (both & (d[31:0] != r[31:0]));
  endfunction

  function automatic logic data_mismatch(input logic [69:0] d, input logic [69:0] r);
    logic both;
    logic fields;
    both   = d[REQ_B] & r[REQ_B];
    fields = (d[ADDR_HI:ADDR_LO] != r[ADDR_HI:ADDR_LO]) |
             (d[WE_B] != r[WE_B]) |
             (d[BE_HI:BE_LO] != r[BE_HI:BE_LO]) |
             (d[WE_B] & (d[WD_HI:0] != r[WD_HI:0]));
    return (d[REQ_B] != r[REQ_B]) | (both & fields);
  endfunction

  logic [32:0]          r_instr_dly [NCYCLES];
  logic [69:0]          r_data_dly  [NCYCLES];
  logic [FILL_W-1:0]    r_fill_cnt;
  state_t               r_state;
  logic                 r_mismatch;
  logic                 r_error;
  logic [ERR_CNT_W-1:0] r_cnt;
  logic [1:0]           r_src;

  logic [FILL_W-1:0]    w_fill_nxt;
  logic                 w_cmp_active;
  logic                 w_mm_instr;
  logic                 w_mm_data;
  logic                 w_mm;
  logic                 w_err_nxt;
  logic [ERR_CNT_W-1:0] w_cnt_nxt;
  logic [1:0]           w_src_nxt;
  state_t               w_state_nxt;
  logic                 w_unused;

  // The instruction channel ignores we/be/wdata, so those bits are never stored.
  assign w_unused = ^{lead_instr_req_i[36:0], trail_instr_req_i[36:0]};

  // Delay line: shift while enabled, flush to zero whenever disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCYCLES; k++) begin
        r_instr_dly[k] <= '0;
        r_data_dly[k]  <= '0;
      end
    end else if (enable_i) begin
      r_instr_dly[0] <= lead_instr_req_i[REQ_B:ADDR_LO];
      r_data_dly[0]  <= lead_data_req_i;
      for (int k = 1; k < NCYCLES; k++) begin
        r_instr_dly[k] <= r_instr_dly[k-1];
        r_data_dly[k]  <= r_data_dly[k-1];
      end
    end else begin
      for (int k = 0; k < NCYCLES; k++) begin
        r_instr_dly[k] <= '0;
        r_data_dly[k]  <= '0;
      end
    end
  end

  // Fill count: shifts since enable rose, saturating once the line is full.
  always_comb begin
    w_fill_nxt = r_fill_cnt;
    if (!enable_i) begin
      w_fill_nxt = '0;
    end else if (r_fill_cnt != FILL_FULL) begin
      w_fill_nxt = r_fill_cnt + FILL_W'(1);
    end
  end

  assign w_cmp_active = enable_i & (r_fill_cnt == FILL_FULL);
  assign w_mm_instr   = w_cmp_active &
                        instr_mismatch(r_instr_dly[NCYCLES-1], trail_instr_req_i[REQ_B:ADDR_LO]);
  assign w_mm_data    = w_cmp_active & data_mismatch(r_data_dly[NCYCLES-1], trail_data_req_i);
  assign w_mm         = w_mm_instr | w_mm_data;

  // Error status: a fresh mismatch overrides a same-cycle clear.
  always_comb begin
    w_err_nxt = r_error;
    w_cnt_nxt = r_cnt;
    w_src_nxt = r_src;
    if (w_mm) begin
      w_err_nxt = 1'b1;
      if (clear_i) begin
        w_cnt_nxt = CNT_ONE;
        w_src_nxt = {w_mm_data, w_mm_instr};
      end else begin
        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
        w_src_nxt = r_src | {w_mm_data, w_mm_instr};
      end
    end else if (clear_i) begin
      w_err_nxt = 1'b0;
      w_cnt_nxt = '0;
      w_src_nxt = '0;
    end
  end

  // Next-state logic; FILL exits according to the error flag it will leave behind.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_FILL;
        S_FILL:  if (w_fill_nxt == FILL_FULL) w_state_nxt = w_err_nxt ? S_FAULT : S_CHECK;
        S_CHECK: if (w_mm) w_state_nxt = S_FAULT;
        S_FAULT: if (clear_i && !w_mm) w_state_nxt = S_CHECK;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fill_cnt <= '0;
      r_state    <= S_IDLE;
      r_mismatch <= 1'b0;
      r_error    <= 1'b0;
      r_cnt      <= '0;
      r_src      <= '0;
    end else begin
      r_fill_cnt <= w_fill_nxt;
      r_state    <= w_state_nxt;
      r_mismatch <= w_mm;
      r_error    <= w_err_nxt;
      r_cnt      <= w_cnt_nxt;
      r_src      <= w_src_nxt;
    end
  end

  assign mismatch_o = r_mismatch;
  assign error_o    = r_error;
  assign err_cnt_o  = r_cnt;
  assign err_src_o  = r_src;
  assign state_o    = r_state;

endmodule

// File: tb/tb_lockstep_cmp.sv
// Testbench for lockstep_cmp: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_lockstep_cmp;

  localparam int N       = 2;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          clr = 1'b0;
  logic [69:0]   li  = '0;
  logic [69:0]   ti  = '0;
  logic [69:0]   ld  = '0;
  logic [69:0]   td  = '0;
  logic          mm_o;
  logic          err_o;
  logic [CW-1:0] cnt_o;
  logic [1:0]    src_o;
  logic [1:0]    st_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: leads seen since enable rose (at most N kept).
  logic [69:0] lq_i[$];
  logic [69:0] lq_d[$];
  bit          m_mm;
  bit          m_err;
  int          m_cnt;
  logic [1:0]  m_src;
  int          m_state;

  always #5 clk = ~clk;

  lockstep_cmp #(.NCYCLES(N), .ERR_CNT_W(CW)) u_dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (en),
    .clear_i           (clr),
    .lead_instr_req_i  (li),
    .trail_instr_req_i (ti),
    .lead_data_req_i   (ld),
    .trail_data_req_i  (td),
    .mismatch_o        (mm_o),
    .error_o           (err_o),
    .err_cnt_o         (cnt_o),
    .err_src_o         (src_o),
    .state_o           (st_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [69:0] mk(bit r, logic [31:0] a, bit w, logic [3:0] b, logic [31:0] wd);
    return {r, a, w, b, wd};
  endfunction

  function automatic logic [69:0] rnd_req();
    return mk($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
  endfunction

  function automatic bit mm_instr(logic [69:0] d, logic [69:0] r);
    if (d[69] != r[69]) return 1'b1;
    if (!d[69]) return 1'b0;
    return d[68:37] != r[68:37];
  endfunction

  function automatic bit mm_data(logic [69:0] d, logic [69:0] r);
    if (d[69] != r[69]) return 1'b1;
    if (!d[69]) return 1'b0;
    if (d[68:37] != r[68:37] || d[36] != r[36] || d[35:32] != r[35:32]) return 1'b1;
    return d[36] && (d[31:0] != r[31:0]);
  endfunction

  // Corruption kinds: 0 req, 1 addr, 2 we, 3 be, 4 wdata (bit 0 of the field).
  function automatic logic [69:0] corrupt(logic [69:0] x, int k);
    logic [69:0] y;
    y = x;
    case (k)
      0: y[69] = ~y[69];
      1: y[37] = ~y[37];
      2: y[36] = ~y[36];
      3: y[32] = ~y[32];
      default: y[0] = ~y[0];
    endcase
    return y;
  endfunction

  function automatic logic [69:0] al_i();
    if (lq_i.size() == N) return lq_i[0];
    return '0;
  endfunction

  function automatic logic [69:0] al_d();
    if (lq_d.size() == N) return lq_d[0];
    return '0;
  endfunction

  function automatic logic [69:0] lead_i(int k);
    return mk(1'b1, 32'h100 + 32'(4 * k), 1'b0, 4'hF, 32'h0);
  endfunction

  task automatic model_reset();
    lq_i.delete();
    lq_d.delete();
    m_mm    = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
    m_src   = 2'b00;
    m_state = 0;
  endtask

  task automatic model_update();
    bit mi;
    bit md;
    mi = 1'b0;
    md = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (en && lq_i.size() == N) begin
      mi = mm_instr(lq_i[0], ti);
      md = mm_data(lq_d[0], td);
    end
    m_mm = mi | md;
    if (m_mm) begin
      m_err = 1'b1;
      if (clr) begin
        m_cnt = 1;
        m_src = {md, mi};
      end else begin
        if (m_cnt < CNT_MAX) m_cnt++;
        m_src = m_src | {md, mi};
      end
    end else if (clr) begin
      m_err = 1'b0;
      m_cnt = 0;
      m_src = 2'b00;
    end
    if (en) begin
      lq_i.push_back(li);
      lq_d.push_back(ld);
      if (lq_i.size() > N) begin
        void'(lq_i.pop_front());
        void'(lq_d.pop_front());
      end
    end else begin
      lq_i.delete();
      lq_d.delete();
    end
    if (!en) m_state = 0;
    else begin
      case (m_state)
        0: m_state = 1;
        1: if (lq_i.size() == N) m_state = m_err ? 3 : 2;
        2: if (m_mm) m_state = 3;
        default: if (clr && !m_mm) m_state = 2;
      endcase
    end
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ".mm"},    32'(mm_o),  32'(m_mm));
    chk({ph, ".err"},   32'(err_o), 32'(m_err));
    chk({ph, ".cnt"},   32'(cnt_o), 32'(m_cnt));
    chk({ph, ".src"},   32'(src_o), 32'(m_src));
    chk({ph, ".state"}, 32'(st_o),  32'(m_state));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_update();
    #1;
    compare_all(ph);
  endtask

  // One cycle: trail requests are the aligned leads, optionally corrupted (k<0: clean).
  task automatic cyc(input bit e, input bit c, input logic [69:0] l_i, input logic [69:0] l_d,
                     input int ki, input int kd, input string ph);
    en  = e;
    clr = c;
    ti  = (ki < 0) ? al_i() : corrupt(al_i(), ki);
    td  = (kd < 0) ? al_d() : corrupt(al_d(), kd);
    li  = l_i;
    ld  = l_d;
    step(ph);
  endtask

  initial begin
    bit any_mm;
    int off;
    model_reset();

    // Reset held with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom_range(0, 1)); clr = 1'($urandom_range(0, 1));
      li = rnd_req(); ti = rnd_req(); ld = rnd_req(); td = rnd_req();
      step("rst");
      chk("rst.state0", 32'(st_o), 32'd0);
    end
    rst = 1'b0;
    en = 1'b0; clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("idle");
      chk("idle.state0", 32'(st_o), 32'd0);
    end

    // Clean aligned run
    any_mm = 1'b0;
    cyc(1, 0, lead_i(0), '0, -1, -1, "t2");
    chk("t2.fill", 32'(st_o), 32'd1);
    cyc(1, 0, lead_i(1), '0, -1, -1, "t2");
    chk("t2.check", 32'(st_o), 32'd2);
    for (int k = 2; k < 50; k++) begin
      cyc(1, 0, lead_i(k), '0, -1, -1, "t2");
      any_mm |= mm_o;
    end
    chk("t2.nomm", 32'(any_mm), 32'd0);

    // Data write diverges in wdata only
    cyc(1, 0, lead_i(50), mk(1, 32'h2000, 1, 4'hF, 32'hDEADBEEF), -1, -1, "t3");
    cyc(1, 0, lead_i(51), mk(1, 32'h2000, 1, 4'hF, 32'hDEADBEEF), -1, -1, "t3");
    cyc(1, 0, lead_i(52), mk(1, 32'h2000, 1, 4'hF, 32'hDEADBEEF), -1, 4, "t3");
    chk("t3.mm",    32'(mm_o),  32'd1);
    chk("t3.err",   32'(err_o), 32'd1);
    chk("t3.cnt",   32'(cnt_o), 32'd1);
    chk("t3.src",   32'(src_o), 32'd2);
    chk("t3.state", 32'(st_o),  32'd3);
    cyc(1, 0, lead_i(53), mk(1, 32'h2000, 0, 4'h3, 32'h0), -1, -1, "t3");
    chk("t3.pulse", 32'(mm_o), 32'd0);

    // Ignored fields: data wdata with we=0, instr we/be
    any_mm = 1'b0;
    for (int k = 54; k < 60; k++) begin
      cyc(1, 0, lead_i(k), mk(1, 32'h3000, 0, 4'h3, $urandom), -1, (k >= 56) ? 4 : -1, "t4");
      any_mm |= mm_o;
    end
    for (int k = 60; k < 64; k++) begin
      cyc(1, 0, lead_i(k), mk(1, 32'h3000, 0, 4'h3, 32'h0), 2 + (k % 2), -1, "t4");
      any_mm |= mm_o;
    end
    chk("t4.nomm", 32'(any_mm), 32'd0);
    chk("t4.cnt",  32'(cnt_o),  32'd1);

    // Saturation with both channels mismatching together
    cyc(1, 1, lead_i(64), mk(1, 32'h3000, 0, 4'h3, 32'h0), -1, -1, "t5");
    chk("t5.clr_state", 32'(st_o),  32'd2);
    chk("t5.clr_err",   32'(err_o), 32'd0);
    for (int k = 65; k < 70; k++)
      cyc(1, 0, lead_i(k), mk(1, 32'h3000, 0, 4'h3, 32'h0), 1, 1, "t5");
    chk("t5.cnt", 32'(cnt_o), 32'd3);
    chk("t5.src", 32'(src_o), 32'd3);
    chk("t5.err", 32'(err_o), 32'd1);

    // clear against a mismatch, then clear alone
    cyc(1, 1, lead_i(70), mk(1, 32'h3000, 0, 4'h3, 32'h0), -1, 1, "t6");
    chk("t6.err", 32'(err_o), 32'd1);
    chk("t6.cnt", 32'(cnt_o), 32'd1);
    chk("t6.src", 32'(src_o), 32'd2);
    cyc(1, 1, lead_i(71), mk(1, 32'h3000, 0, 4'h3, 32'h0), -1, -1, "t6");
    chk("t6.clr_cnt",   32'(cnt_o), 32'd0);
    chk("t6.clr_state", 32'(st_o),  32'd2);

    // Fill restart after dropping enable mid-FILL
    cyc(0, 0, lead_i(72), '0, -1, -1, "t6f");
    chk("t6f.idle", 32'(st_o), 32'd0);
    cyc(1, 0, lead_i(80), '0, -1, -1, "t6f");
    chk("t6f.fill", 32'(st_o), 32'd1);
    cyc(0, 0, lead_i(81), '0, -1, -1, "t6f");
    chk("t6f.drop", 32'(st_o), 32'd0);
    cyc(1, 0, lead_i(90), '0, -1, -1, "t6f");
    chk("t6f.refill", 32'(st_o), 32'd1);
    cyc(1, 0, lead_i(91), '0, 0, -1, "t6f");
    chk("t6f.nocmp", 32'(mm_o), 32'd0);
    cyc(1, 0, lead_i(92), '0, 1, -1, "t6f");
    chk("t6f.first", 32'(mm_o), 32'd1);

    // Randomized traffic with enable drops, clears and one async reset
    off = 0;
    for (int i = 0; i < 1500; i++) begin
      bit e;
      bit c;
      int ki;
      int kd;
      if (off > 0) begin
        off--;
        e = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        off = $urandom_range(0, 2);
        e = 1'b0;
      end else begin
        e = 1'b1;
      end
      c  = ($urandom_range(0, 19) == 0);
      ki = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      kd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      cyc(e, c, rnd_req(), rnd_req(), ki, kd, "rnd");
      if (i == 700) begin
        rst = 1'b1;
        #2;
        model_reset();
        compare_all("arst");
        step("arst");
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
